command_arbiter: RTL and testbench

// - Shares the single 8-bit command port (cmd_data/cmd_val/cmd_ack) of the command interface unit among N_REQ requesters.
// - Requesters: safety supervisor, host link, teach pendant, etc.
// - Requester 0 (safety) has fixed highest priority; requesters 1..N_REQ-1 are served round-robin.
// - Issues one command at a time and waits for cmd_ack, bounded by a timeout.
// - Reports completion or failure back to the owning requester.

---
 rtl/command_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_command_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/command_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : command_arbiter
// Purpose : Shares one 8-bit command port among N_REQ requesters. Requester 0
//           has fixed priority and the rest are served round-robin. Each
//           command waits for an ack, bounded by ACK_TIMEOUT cycles.
//           Optional macro CMD_ARB_FILTER_EN rejects opcodes outside the
//           legal set.
// Rev     : 1.0
// ============================================================================
module command_arbiter #(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_REQ*8-1:0] i_req_data,
   input  logic [N_REQ-1:0]   i_req_val,
   output logic [N_REQ-1:0]   o_req_rdy,
   output logic [N_REQ-1:0]   o_req_done,
   output logic [N_REQ-1:0]   o_req_err,
   output logic [7:0]         o_cmd_data,
   output logic               o_cmd_val,
   input  logic               i_cmd_ack,
   output logic               o_busy,
   output logic [ID_W-1:0]    o_grant_id
);

   localparam int               TMR_W      = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_WAIT_ACK = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [ID_W-1:0]    r_rr_ptr, w_rr_nxt;
   logic [ID_W-1:0]    r_grant_id, w_grant_nxt;
   logic [TMR_W-1:0]   r_timer, w_timer_nxt;
   logic [7:0]         r_cmd_data, w_cmd_data_nxt;
   logic               r_cmd_val, w_cmd_val_nxt;
   logic               r_busy;
   logic [N_REQ-1:0]   r_req_rdy, w_rdy_nxt;
   logic [N_REQ-1:0]   r_req_done, w_done_nxt;
   logic [N_REQ-1:0]   r_req_err, w_err_nxt;

   logic [ID_W-1:0]    w_win;
   logic [7:0]         w_win_data;
   logic [N_REQ-1:0]   w_win_oh;
   logic [N_REQ-1:0]   w_own_oh;
   logic               w_legal;
   int                 w_rr_base;
   int                 w_off;
   int                 w_best;

   // Round-robin distance of each requester 1..N_REQ-1 from the slot after
   // rr_ptr; a pointer of 0 behaves like N_REQ-1 so the scan starts at 1.
   always_comb begin
      w_rr_base = (r_rr_ptr == '0) ? (N_REQ - 1) : int'(r_rr_ptr);
      w_off     = 0;
      w_best    = N_REQ;
      w_win     = '0;
      for (int i = 1; i < N_REQ; i++) begin
         w_off = i - w_rr_base + N_REQ - 2;
         if (w_off >= N_REQ - 1) begin
            w_off = w_off - (N_REQ - 1);
         end
         if (i_req_val[i] && (w_off < w_best)) begin
            w_best = w_off;
            w_win  = ID_W'(i);
         end
      end
      if (i_req_val[0]) begin
         w_win = '0;
      end
   end

   always_comb begin
      w_win_data = i_req_data[7:0];
      for (int i = 1; i < N_REQ; i++) begin
         if (w_win == ID_W'(i)) begin
            w_win_data = i_req_data[i*8 +: 8];
         end
      end
   end

   assign w_win_oh = N_REQ'(1) << w_win;
   assign w_own_oh = N_REQ'(1) << r_grant_id;

`ifdef CMD_ARB_FILTER_EN
   function automatic logic f_legal(input logic [7:0] op);
      return op inside {8'h04, 8'h14, 8'h50, 8'h54};
   endfunction
   assign w_legal = f_legal(w_win_data);
`else
   assign w_legal = 1'b1;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_rr_nxt       = r_rr_ptr;
      w_grant_nxt    = r_grant_id;
      w_timer_nxt    = r_timer;
      w_cmd_data_nxt = r_cmd_data;
      w_cmd_val_nxt  = 1'b0;
      w_rdy_nxt      = '0;
      w_done_nxt     = '0;
      w_err_nxt      = '0;
      case (r_state)
         S_IDLE: begin
            if (|i_req_val) begin
               w_grant_nxt = w_win;
               w_rdy_nxt   = w_win_oh;
               if (w_win != '0) begin
                  w_rr_nxt = w_win;
               end
               if (w_legal) begin
                  w_cmd_data_nxt = w_win_data;
                  w_cmd_val_nxt  = 1'b1;
                  w_state_nxt    = S_ISSUE;
               end else begin
                  w_err_nxt = w_win_oh;
               end
            end
         end
         S_ISSUE: begin
            w_timer_nxt = '0;
            if (i_cmd_ack) begin
               w_done_nxt  = w_own_oh;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            // Ack is checked first so an ack in the last window cycle wins.
            if (i_cmd_ack) begin
               w_done_nxt  = w_own_oh;
               w_state_nxt = S_IDLE;
            end else if (r_timer >= C_TMR_LAST) begin
               w_err_nxt   = w_own_oh;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_timer    <= '0;
         r_cmd_data <= 8'h00;
         r_cmd_val  <= 1'b0;
         r_busy     <= 1'b0;
         r_req_rdy  <= '0;
         r_req_done <= '0;
         r_req_err  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_nxt;
         r_grant_id <= w_grant_nxt;
         r_timer    <= w_timer_nxt;
         r_cmd_data <= w_cmd_data_nxt;
         r_cmd_val  <= w_cmd_val_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_req_rdy  <= w_rdy_nxt;
         r_req_done <= w_done_nxt;
         r_req_err  <= w_err_nxt;
      end
   end

   assign o_req_rdy  = r_req_rdy;
   assign o_req_done = r_req_done;
   assign o_req_err  = r_req_err;
   assign o_cmd_data = r_cmd_data;
   assign o_cmd_val  = r_cmd_val;
   assign o_busy     = r_busy;
   assign o_grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_command_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_command_arbiter
// Purpose : Random requesters and ack responder against a timestamp-based
//           transaction model of the arbiter (CMD_ARB_FILTER_EN aware).
// Rev     : 1.0
// ============================================================================
module tb_command_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int TO  = 16;
`ifdef CMD_ARB_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N*8-1:0] req_data = '0;
   logic [N-1:0]   req_val = '0;
   logic [N-1:0]   req_rdy, req_done, req_err;
   logic [7:0]     cmd_data;
   logic           cmd_val;
   logic           cmd_ack = 1'b0;
   logic           busy;
   logic [IDW-1:0] grant_id;

   command_arbiter #(.N_REQ(N), .ID_W(IDW), .ACK_TIMEOUT(TO)) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req_data (req_data),
      .i_req_val  (req_val),
      .o_req_rdy  (req_rdy),
      .o_req_done (req_done),
      .o_req_err  (req_err),
      .o_cmd_data (cmd_data),
      .o_cmd_val  (cmd_val),
      .i_cmd_ack  (cmd_ack),
      .o_busy     (busy),
      .o_grant_id (grant_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Model: each transaction is a set of absolute cycle stamps.
   int          cyc    = 0;
   int          m_free = 0;
   int          m_rr   = 0;
   int          m_grant = 0;
   logic [7:0]  m_data = 8'h00;
   int          owner  = 0;
   int          t_rdy  = -1;
   int          t_cmd  = -1;
   int          t_ack  = -1;
   int          t_end  = -1;
   bit          end_err = 1'b0;
   int          n_tx   = 0;
   logic [7:0]  opc [N];
   logic [N-1:0] val = '0;
   logic [7:0]  ops [6] = '{8'h04, 8'h14, 8'h50, 8'h54, 8'hFF, 8'h33};

   function automatic int pick(input logic [N-1:0] v, input int rr);
      if (v[0]) return 0;
      for (int k = 1; k < N; k++) begin
         if (v[((rr + k - 1) % (N - 1)) + 1]) return ((rr + k - 1) % (N - 1)) + 1;
      end
      return -1;
   endfunction

   function automatic bit legal(input logic [7:0] op);
      return !FILTER || (op inside {8'h04, 8'h14, 8'h50, 8'h54});
   endfunction

   task automatic check_cycle();
      logic [N-1:0] oh;
      oh = N'(1) << owner;
      check("rdy",      32'(req_rdy),  (cyc == t_rdy) ? 32'(oh) : 32'd0);
      check("cmd_val",  32'(cmd_val),  32'(cyc == t_cmd));
      check("done",     32'(req_done), (cyc == t_end && !end_err) ? 32'(oh) : 32'd0);
      check("err",      32'(req_err),  (cyc == t_end &&  end_err) ? 32'(oh) : 32'd0);
      check("busy",     32'(busy),     32'(t_cmd >= 0 && cyc >= t_cmd && cyc < t_end));
      check("cmd_data", 32'(cmd_data), 32'(m_data));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      if (|req_done) n_done++;
      if (|req_err)  n_err++;
   endtask

   // Requester/responder activity for the current cycle plus the grant
   // decision taken at the coming edge.
   task automatic plan();
      logic [N-1:0] oh;
      int w;
      int d;
      oh = (cyc == t_rdy) ? (N'(1) << owner) : '0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) begin
            val[i] = 1'b0;
         end else if (!val[i] && ($urandom_range(0, 99) < ((i == 0) ? 3 : 15))) begin
            val[i] = 1'b1;
            opc[i] = ops[$urandom_range(0, 5)];
         end
      end
      req_val = val;
      for (int i = 0; i < N; i++) req_data[i*8 +: 8] = opc[i];
      cmd_ack = (t_ack >= 0 && cyc == t_ack);
      if (cyc >= m_free && |val) begin
         w       = pick(val, m_rr);
         owner   = w;
         m_grant = w;
         if (w != 0) m_rr = w;
         t_rdy   = cyc + 1;
         if (!legal(opc[w])) begin
            t_cmd   = -1;
            t_ack   = -1;
            t_end   = cyc + 1;
            end_err = 1'b1;
         end else begin
            n_tx++;
            m_data = opc[w];
            t_cmd  = cyc + 1;
            case (n_tx % 6)
               1:       d = TO;
               3:       d = TO + 5;
               5:       d = 0;
               default: d = $urandom_range(1, 8);
            endcase
            if (d <= TO) begin
               t_ack   = t_cmd + d;
               t_end   = t_cmd + d + 1;
               end_err = 1'b0;
            end else begin
               t_ack   = -1;
               t_end   = t_cmd + TO + 1;
               end_err = 1'b1;
            end
         end
         m_free = t_end;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rdy"},  32'(req_rdy),  32'd0);
      check({tag, "_done"}, 32'(req_done), 32'd0);
      check({tag, "_err"},  32'(req_err),  32'd0);
      check({tag, "_val"},  32'(cmd_val),  32'd0);
      check({tag, "_busy"}, 32'(busy),     32'd0);
      check({tag, "_data"}, 32'(cmd_data), 32'd0);
      check({tag, "_gnt"},  32'(grant_id), 32'd0);
   endtask

   task automatic reset_model();
      m_free  = 0;
      m_rr    = 0;
      m_grant = 0;
      m_data  = 8'h00;
      owner   = 0;
      t_rdy   = -1;
      t_cmd   = -1;
      t_ack   = -1;
      t_end   = -1;
      cmd_ack = 1'b0;
   endtask

   bit did_mid_reset = 1'b0;

   initial begin
      for (int i = 0; i < N; i++) opc[i] = 8'h00;
      #1;
      check_zero("por");
      repeat (2) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      plan();
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         cyc++;
         #1;
         check_cycle();
         plan();
         if (!did_mid_reset && cyc > 600 && t_cmd >= 0 && cyc > t_cmd && cyc + 2 < t_end) begin
            // Abandon a transfer that is waiting for its ack.
            did_mid_reset = 1'b1;
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_zero("arst");
            reset_model();
            repeat (2) begin
               @(posedge clk);
               cyc++;
               #1;
               check_zero("inrst");
            end
            @(negedge clk);
            rst_n = 1'b1;
            plan();
         end
      end
      check("saw_done",   32'(n_done > 0), 32'd1);
      check("saw_err",    32'(n_err > 0),  32'd1);
      check("saw_reset",  32'(did_mid_reset), 32'd1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
